// File: rtl/pipe_stage_chain_if.sv
// Entry/exit handshake bundle for pipe_stage_chain.
// A transfer happens on a rising clock edge where valid and ready are both high; valid never waits on ready.
interface pipe_stage_chain_if #(
   parameter int DATA_W = 64
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;

   modport master (
      output in_valid,
      output in_data,
      output out_ready,
      input  in_ready,
      input  out_valid
   );

   modport slave (
      input  in_valid,
      input  in_data,
      input  out_ready,
      output in_ready,
      output out_valid
   );
endinterface

// File: rtl/pipe_stage_chain.sv
// N-stage pipeline register chain: per-stage valid, back-pressure, partial flush and retire counter.
// Optional performance counters are built only when PIPE_PERF_EN is defined.
module pipe_stage_chain #(
   parameter int STAGES  = 4,
   parameter int DATA_W  = 64,
   parameter int ORDER_W = 64,
   parameter int PERF_W  = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   pipe_stage_chain_if.slave          bus,
   input  logic [STAGES-1:0]          stall_i,
   input  logic                       flush_i,
   input  logic [$clog2(STAGES)-1:0]  flush_stage_i,
   output logic [STAGES-1:0]          stage_valid_o,
   output logic [STAGES*DATA_W-1:0]   stage_data_o,
   output logic                       retire_o,
   output logic [ORDER_W-1:0]         order_o,
   output logic [PERF_W-1:0]          perf_stall_o,
   output logic [PERF_W-1:0]          perf_flush_o,
   output logic [PERF_W-1:0]          perf_bubble_o
);

   localparam int FW = $clog2(STAGES);
   localparam logic [FW-1:0] F_MAX = FW'(STAGES - 2);

   logic [STAGES-1:0] valid_q;
   logic [DATA_W-1:0] data_q [STAGES];
   logic [STAGES-1:0] hold;
   logic [STAGES-1:0] kill;
   logic [STAGES-1:0] src_valid;
   logic [FW-1:0]     f_lim;
   logic              in_ready;
   logic [ORDER_W-1:0] order_q;

   // Hold propagates from the oldest stage toward the youngest.
   always_comb begin
      hold = '0;
      hold[STAGES-1] = stall_i[STAGES-1] | (valid_q[STAGES-1] & ~bus.out_ready);
      for (int k = STAGES - 2; k >= 0; k--) begin
         hold[k] = stall_i[k] | hold[k+1];
      end
   end

   // The retiring stage is never flushed, so the flush range is clamped below it.
   always_comb begin
      f_lim = (flush_stage_i > F_MAX) ? F_MAX : flush_stage_i;
      kill  = '0;
      for (int k = 0; k < STAGES - 1; k++) begin
         kill[k] = flush_i & (FW'(k) <= f_lim);
      end
   end

   assign in_ready = rst & ~hold[0] & ~flush_i;

   // Valid presented to each stage when it loads; a held or flushed source yields a bubble.
   always_comb begin
      src_valid    = '0;
      src_valid[0] = bus.in_valid & in_ready;
      for (int k = 1; k < STAGES; k++) begin
         src_valid[k] = valid_q[k-1] & ~hold[k-1] & ~kill[k-1];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         valid_q <= '0;
         for (int k = 0; k < STAGES; k++) begin
            data_q[k] <= '0;
         end
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            if (kill[k]) begin
               valid_q[k] <= 1'b0;
            end else if (!hold[k]) begin
               valid_q[k] <= src_valid[k];
            end
         end
         if (!hold[0]) begin
            data_q[0] <= bus.in_data;
         end
         // A bubble caused by a held source leaves the destination payload untouched.
         for (int k = 1; k < STAGES; k++) begin
            if (!hold[k] && !hold[k-1]) begin
               data_q[k] <= data_q[k-1];
            end
         end
      end
   end

   assign retire_o = valid_q[STAGES-1] & ~hold[STAGES-1];

   always_ff @(posedge clk) begin
      if (!rst) begin
         order_q <= '0;
      end else if (retire_o) begin
         order_q <= order_q + ORDER_W'(1);
      end
   end

   assign order_o       = order_q;
   assign bus.in_ready  = in_ready;
   assign bus.out_valid = valid_q[STAGES-1];
   assign stage_valid_o = valid_q;

   for (genvar g = 0; g < STAGES; g++) begin : g_data_out
      assign stage_data_o[g*DATA_W +: DATA_W] = data_q[g];
   end

`ifdef PIPE_PERF_EN
   logic [PERF_W-1:0] stall_q;
   logic [PERF_W-1:0] flush_q;
   logic [PERF_W-1:0] bubble_q;
   logic [PERF_W-1:0] bubble_n;
   logic              stall_ev;

   function automatic logic [PERF_W-1:0] sat_add(input logic [PERF_W-1:0] a,
                                                 input logic [PERF_W-1:0] b);
      logic [PERF_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[PERF_W] ? {PERF_W{1'b1}} : s[PERF_W-1:0];
   endfunction

   // A bubble is counted where a held stage feeds a stage that is free to load.
   always_comb begin
      bubble_n = '0;
      for (int k = 0; k < STAGES - 1; k++) begin
         if (hold[k] && !hold[k+1]) begin
            bubble_n = bubble_n + PERF_W'(1);
         end
      end
   end

   assign stall_ev = |(hold & valid_q);

   always_ff @(posedge clk) begin
      if (!rst) begin
         stall_q  <= '0;
         flush_q  <= '0;
         bubble_q <= '0;
      end else begin
         stall_q  <= sat_add(stall_q, PERF_W'(stall_ev));
         flush_q  <= sat_add(flush_q, PERF_W'(flush_i));
         bubble_q <= sat_add(bubble_q, bubble_n);
      end
   end

   assign perf_stall_o  = stall_q;
   assign perf_flush_o  = flush_q;
   assign perf_bubble_o = bubble_q;
`else
   assign perf_stall_o  = '0;
   assign perf_flush_o  = '0;
   assign perf_bubble_o = '0;
`endif

endmodule
